// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W_DEF   = 6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MD,
        ST_XWAIT,
        ST_XFLUSH
    } hz_state_e;

    typedef struct packed {
        logic stall;
        logic bubble;
    } stage_ctl_t;

    // Register 0 is hard-wired, so it can never be the subject of an interlock.
    function automatic logic load_use(input logic [4:0] src1,
                                      input logic [4:0] src2,
                                      input logic [4:0] dst,
                                      input logic       is_load);
        return is_load && (dst != 5'd0) && ((src1 == dst) || (src2 == dst));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] d_src1;
    logic [4:0] d_src2;
    logic [4:0] e_dst;
    logic       e_isLoad;
    logic [4:0] m_dst;
    logic       m_isLoad;
    logic       e_mdStart;
    logic       e_mdIsDiv;
    logic       d_useHiLo;
    logic       i_busy;
    logic       m_busy;
    logic       exception;
    logic       d_isERET;

    logic       F_stall;
    logic       D_stall;
    logic       E_stall;
    logic       M_stall;
    logic       W_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_bubble;
    logic       redirect;
    logic       md_busy;

    modport master (
        output d_src1, d_src2, e_dst, e_isLoad, m_dst, m_isLoad,
               e_mdStart, e_mdIsDiv, d_useHiLo, i_busy, m_busy,
               exception, d_isERET,
        input  F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble, redirect, md_busy
    );

    modport slave (
        input  d_src1, d_src2, e_dst, e_isLoad, m_dst, m_isLoad,
               e_mdStart, e_mdIsDiv, d_useHiLo, i_busy, m_busy,
               exception, d_isERET,
        output F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble, redirect, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_md_counter.sv
// Mul/div occupancy countdown: load, decrement, clear, zero flag.
module md_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Per-stage stall/bubble generation for the 5-stage core.
//   state  | meaning
//   RUN    | normal issue, only data/bus hazards apply
//   MD     | mul/div occupies E, counter counts down to 0
//   XWAIT  | exception/ERET seen, freezing until both buses idle
//   XFLUSH | one-cycle redirect with D/E/M flushed
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    hz_state_e        state;
    logic             first_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             md_load;
    logic             md_dec;
    logic             md_clr;
    logic [CNT_W-1:0] md_load_val;
    logic             flush_evt;
    logic             busy_any;
    logic             md_hold;
    logic             lu_hit;
    logic             mask;
    logic             f_stall;
    stage_ctl_t       ctl_d, ctl_e, ctl_m, ctl_w;

    assign flush_evt = hz.exception | hz.d_isERET;
    assign busy_any  = hz.i_busy | hz.m_busy;

    // At counter 0 the unit finishes this cycle, so a waiting mul/div may issue.
    assign md_hold = (state == ST_MD) && !cnt_zero && (hz.d_useHiLo || hz.e_mdStart);
    assign lu_hit  = load_use(hz.d_src1, hz.d_src2, hz.e_dst, hz.e_isLoad) |
                     load_use(hz.d_src1, hz.d_src2, hz.m_dst, hz.m_isLoad);

    assign md_load_val = hz.e_mdIsDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    assign md_clr      = (state == ST_XFLUSH);
    assign md_load     = hz.e_mdStart && !flush_evt &&
                         ((state == ST_RUN) || ((state == ST_MD) && cnt_zero));
    assign md_dec      = (state == ST_MD) && !flush_evt && !cnt_zero;

    md_counter #(.CNT_W(CNT_W)) u_md_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .dec      (md_dec),
        .clr      (md_clr),
        .load_val (md_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (flush_evt)
                        state <= busy_any ? ST_XWAIT : ST_XFLUSH;
                    else if (hz.e_mdStart)
                        state <= ST_MD;
                end
                ST_MD: begin
                    if (flush_evt)
                        state <= busy_any ? ST_XWAIT : ST_XFLUSH;
                    else if (cnt_zero && !hz.e_mdStart)
                        state <= ST_RUN;
                end
                ST_XWAIT: begin
                    if (!busy_any)
                        state <= ST_XFLUSH;
                end
                ST_XFLUSH: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        f_stall = 1'b0;
        ctl_d   = '0;
        ctl_e   = '0;
        ctl_m   = '0;
        ctl_w   = '0;
        if (state == ST_XFLUSH) begin
            ctl_d.bubble = 1'b1;
            ctl_e.bubble = 1'b1;
            ctl_m.bubble = 1'b1;
        end else if (state == ST_XWAIT) begin
            f_stall     = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.stall = 1'b1;
            ctl_m.stall = 1'b1;
            ctl_w.stall = 1'b1;
        end else if (hz.m_busy) begin
            f_stall      = 1'b1;
            ctl_d.stall  = 1'b1;
            ctl_e.stall  = 1'b1;
            ctl_m.stall  = 1'b1;
            ctl_w.bubble = 1'b1;
        end else if (md_hold) begin
            f_stall      = 1'b1;
            ctl_d.stall  = 1'b1;
            ctl_e.stall  = 1'b1;
            ctl_m.bubble = 1'b1;
        end else if (lu_hit) begin
            f_stall      = 1'b1;
            ctl_d.stall  = 1'b1;
            ctl_e.bubble = 1'b1;
        end else if (hz.i_busy) begin
            f_stall      = 1'b1;
            ctl_d.bubble = 1'b1;
        end
    end

    // Outputs stay quiet during reset and for the first cycle out of it.
    assign mask = reset | first_q;

    assign hz.F_stall  = f_stall      & ~mask;
    assign hz.D_stall  = ctl_d.stall  & ~mask;
    assign hz.E_stall  = ctl_e.stall  & ~mask;
    assign hz.M_stall  = ctl_m.stall  & ~mask;
    assign hz.W_stall  = ctl_w.stall  & ~mask;
    assign hz.D_bubble = ctl_d.bubble & ~mask;
    assign hz.E_bubble = ctl_e.bubble & ~mask;
    assign hz.M_bubble = ctl_m.bubble & ~mask;
    assign hz.W_bubble = ctl_w.bubble & ~mask;
    assign hz.redirect = (state == ST_XFLUSH) & ~mask;
    assign hz.md_busy  = (state == ST_MD) & ~mask;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic.
module tb_hazard_ctrl;

    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] ed;
        logic       el;
        logic [4:0] md;
        logic       ml;
        logic       ms;
        logic       mdiv;
        logic       hilo;
        logic       ib;
        logic       mb;
        logic       exc;
        logic       eret;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    logic [10:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    // Reference model: remaining busy cycles of the mul/div unit, plus flush bookkeeping.
    int md_rem     = 0;
    bit waiting    = 0;
    bit flush_now  = 0;
    bit first_cyc  = 1;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] dst, input logic ld);
        return ld && dst != 0 && (a == dst || b == dst);
    endfunction

    // {F_stall,D_stall,E_stall,M_stall,W_stall,D_bubble,E_bubble,M_bubble,W_bubble,redirect,md_busy}
    function automatic logic [10:0] model_out(input stim_t s);
        logic [10:0] o;
        o = '0;
        if (s.rst || first_cyc) return o;
        if (flush_now) begin
            o[5] = 1; o[4] = 1; o[3] = 1; o[1] = 1;
            return o;
        end
        if (waiting)                              o[10:6] = 5'b11111;
        else if (s.mb)                            begin o[10:7] = 4'b1111; o[2] = 1; end
        else if (md_rem > 1 && (s.hilo || s.ms))  begin o[10:8] = 3'b111;  o[3] = 1; end
        else if (dep(s.s1, s.s2, s.ed, s.el) || dep(s.s1, s.s2, s.md, s.ml))
                                                  begin o[10:9] = 2'b11;   o[4] = 1; end
        else if (s.ib)                            begin o[10] = 1;          o[5] = 1; end
        o[0] = (md_rem > 0);
        return o;
    endfunction

    task automatic model_adv(input stim_t s);
        int lat;
        lat = s.mdiv ? DIV_CYC : MUL_CYC;
        if (s.rst) begin
            md_rem = 0; waiting = 0; flush_now = 0; first_cyc = 1;
            return;
        end
        first_cyc = 0;
        if (flush_now) begin
            flush_now = 0; md_rem = 0;
        end else if (waiting) begin
            if (!s.ib && !s.mb) begin waiting = 0; flush_now = 1; end
        end else if (s.exc || s.eret) begin
            md_rem = 0;
            if (s.ib || s.mb) waiting = 1; else flush_now = 1;
        end else if (md_rem == 1) begin
            md_rem = s.ms ? lat : 0;
        end else if (md_rem > 1) begin
            md_rem = md_rem - 1;
        end else if (s.ms) begin
            md_rem = lat;
        end
    endtask

    task automatic apply(input stim_t s);
        reset        = s.rst;
        hz.d_src1    = s.s1;
        hz.d_src2    = s.s2;
        hz.e_dst     = s.ed;
        hz.e_isLoad  = s.el;
        hz.m_dst     = s.md;
        hz.m_isLoad  = s.ml;
        hz.e_mdStart = s.ms;
        hz.e_mdIsDiv = s.mdiv;
        hz.d_useHiLo = s.hilo;
        hz.i_busy    = s.ib;
        hz.m_busy    = s.mb;
        hz.exception = s.exc;
        hz.d_isERET  = s.eret;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        exp_q.push_back(model_out(s));
        model_adv(s);
    endtask

    always @(negedge clk) begin
        logic [10:0] got;
        logic [10:0] exp;
        if (exp_q.size() > 0) begin
            got = {hz.F_stall, hz.D_stall, hz.E_stall, hz.M_stall, hz.W_stall,
                   hz.D_bubble, hz.E_bubble, hz.M_bubble, hz.W_bubble,
                   hz.redirect, hz.md_busy};
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stage_ctl cyc=%0d got=%b expected=%b", cyc, got, exp);
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1;
        apply(s);

        step(s); step(s);
        s = idle(); step(s); step(s);

        // load-use: LW r5 in E, ADDU r6,r5,r1 in D, then load moves to M
        s = idle(); s.s1 = 5; s.s2 = 1; s.ed = 5; s.el = 1; step(s);
        s = idle(); s.s1 = 5; s.s2 = 1; s.md = 5; s.ml = 1; step(s);
        s = idle(); s.s1 = 5; s.s2 = 1; step(s);
        // r0 never interlocks
        s = idle(); s.el = 1; s.ml = 1; step(s);

        // DIV followed by MFLO
        s = idle(); s.ms = 1; s.mdiv = 1; s.hilo = 1; step(s);
        s = idle(); s.hilo = 1;
        for (int i = 0; i < DIV_CYC + 2; i++) step(s);

        // m_busy over a pending load-use
        s = idle(); s.s1 = 7; s.ed = 7; s.el = 1; s.mb = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.mb = 0; step(s);
        s = idle(); step(s);

        // exception while fetch outstanding
        s = idle(); s.exc = 1; s.ib = 1; step(s);
        s = idle(); s.ib = 1; step(s);
        s = idle();
        for (int i = 0; i < 4; i++) step(s);

        // MUL, then exception+ERET together in MD
        s = idle(); s.ms = 1; step(s);
        s = idle(); step(s);
        s.exc = 1; s.eret = 1; step(s);
        s = idle();
        for (int i = 0; i < 3; i++) step(s);

        // back-to-back MULs
        s = idle(); s.ms = 1;
        for (int i = 0; i < 2 * MUL_CYC + 2; i++) step(s);

        // reset in the middle of a divide
        s = idle(); s.ms = 1; s.mdiv = 1; step(s);
        s = idle(); s.hilo = 1;
        for (int i = 0; i < 15; i++) step(s);
        s.rst = 1; step(s);
        s.rst = 0; step(s); step(s); step(s);

        for (int i = 0; i < 3000; i++) begin
            s      = idle();
            s.rst  = ($urandom_range(0, 299) == 0);
            s.s1   = 5'($urandom_range(0, 3));
            s.s2   = 5'($urandom_range(0, 3));
            s.ed   = 5'($urandom_range(0, 3));
            s.md   = 5'($urandom_range(0, 3));
            s.el   = ($urandom_range(0, 9) < 3);
            s.ml   = ($urandom_range(0, 9) < 3);
            s.ms   = ($urandom_range(0, 9) == 0);
            s.mdiv = ($urandom_range(0, 3) == 0);
            s.hilo = ($urandom_range(0, 4) == 0);
            s.ib   = ($urandom_range(0, 4) == 0);
            s.mb   = ($urandom_range(0, 6) == 0);
            s.exc  = ($urandom_range(0, 39) == 0);
            s.eret = ($urandom_range(0, 39) == 0);
            step(s);
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
